// File: rtl/dmem_access_unit.sv
// dmem_access_unit: load/store alignment between the memory stage and a
// word-wide data RAM without byte enables. Loads are extracted and
// sign/zero extended; sub-word stores become a read-modify-write pair.
module dmem_access_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid_i,
   input  logic              req_we_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_unsigned_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [31:0]       req_wdata_i,
   output logic              stall_o,
   output logic              misalign_o,
   output logic [31:0]       rdata_o,
   output logic              rdata_valid_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   output logic              mem_write_o,
   output logic              mem_read_o,
   input  logic [31:0]       mem_rdata_i
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD_WAIT = 2'd1,
      RMW_WR    = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [ADDR_W-1:0] addr_r;
   logic [1:0]        size_r;
   logic              unsigned_r;
   logic [15:0]       wdata_r;
   logic              latch_s;
   logic              misalign_s;

   // Half needs addr[0]=0, word (and the 11 encoding) needs addr[1:0]=00.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic r;
      case (size)
         2'b00:   r = 1'b0;
         2'b01:   r = addr_lo[0];
         default: r = (addr_lo != 2'b00);
      endcase
      return r;
   endfunction

   // Pick the addressed lane(s) out of a RAM word and extend to 32 bits.
   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] size, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         2'd3:    b = word[31:24];
         default: b = word[7:0];
      endcase
      if (lane[1]) begin
         h = word[31:16];
      end else begin
         h = word[15:0];
      end
      case (size)
         2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
         2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // Replace the target lane(s) of the old RAM word with right-aligned store data.
   function automatic logic [31:0] merge_store(input logic [31:0] old_word, input logic [15:0] wdata,
                                               input logic [1:0] lane, input logic [1:0] size);
      logic [31:0] r;
      r = old_word;
      case (size)
         2'b00: begin
            case (lane)
               2'd0:    r[7:0]   = wdata[7:0];
               2'd1:    r[15:8]  = wdata[7:0];
               2'd2:    r[23:16] = wdata[7:0];
               2'd3:    r[31:24] = wdata[7:0];
               default: r = old_word;
            endcase
         end
         2'b01: begin
            if (lane[1]) begin
               r[31:16] = wdata;
            end else begin
               r[15:0] = wdata;
            end
         end
         default: r = old_word;
      endcase
      return r;
   endfunction

   // Next state and all memory/core strobes; reset masks every strobe so an
   // interrupted read-modify-write never reaches the RAM.
   always_comb begin
      state_nxt_s   = state_r;
      stall_o       = 1'b0;
      misalign_o    = 1'b0;
      rdata_o       = 32'd0;
      rdata_valid_o = 1'b0;
      mem_addr_o    = {req_addr_i[ADDR_W-1:2], 2'b00};
      mem_wdata_o   = 32'd0;
      mem_write_o   = 1'b0;
      mem_read_o    = 1'b0;
      latch_s       = 1'b0;
      misalign_s    = req_valid_i && is_misaligned(req_size_i, req_addr_i[1:0]);

      case (state_r)
         IDLE, LOAD_WAIT: begin
            state_nxt_s = IDLE;
            if (state_r == LOAD_WAIT) begin
               rdata_valid_o = 1'b1;
               rdata_o       = load_extend(mem_rdata_i, addr_r[1:0], size_r, unsigned_r);
            end else begin
               rdata_valid_o = 1'b0;
            end
            misalign_o = misalign_s;
            if (req_valid_i && !misalign_s) begin
               if (!req_we_i) begin
                  mem_read_o  = 1'b1;
                  latch_s     = 1'b1;
                  state_nxt_s = LOAD_WAIT;
               end else if (req_size_i[1]) begin
                  mem_write_o = 1'b1;
                  mem_wdata_o = req_wdata_i;
               end else begin
                  mem_read_o  = 1'b1;
                  stall_o     = 1'b1;
                  latch_s     = 1'b1;
                  state_nxt_s = RMW_WR;
               end
            end else begin
               latch_s = 1'b0;
            end
         end
         RMW_WR: begin
            mem_addr_o  = {addr_r[ADDR_W-1:2], 2'b00};
            mem_wdata_o = merge_store(mem_rdata_i, wdata_r, addr_r[1:0], size_r);
            mem_write_o = 1'b1;
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase

      if (!reset_n) begin
         stall_o       = 1'b0;
         rdata_o       = 32'd0;
         rdata_valid_o = 1'b0;
         mem_wdata_o   = 32'd0;
         mem_write_o   = 1'b0;
         mem_read_o    = 1'b0;
         latch_s       = 1'b0;
         state_nxt_s   = IDLE;
      end else begin
         state_nxt_s = state_nxt_s;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Capture the accepted request fields needed by the follow-up cycle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         addr_r     <= '0;
         size_r     <= 2'b00;
         unsigned_r <= 1'b0;
         wdata_r    <= 16'd0;
      end else if (latch_s) begin
         addr_r     <= req_addr_i;
         size_r     <= req_size_i;
         unsigned_r <= req_unsigned_i;
         wdata_r    <= req_wdata_i[15:0];
      end
   end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Load/store alignment unit between the core's memory stage and the word-wide data RAM of the simulation harness. Handles byte, halfword and word accesses, including sign/zero extension on loads and read-modify-write for sub-word stores to a RAM with no byte enables. Detects misaligned accesses. Enables the LB/LH/LW/LBU/LHU/SB/SH/SW compliance tests on the existing word RAM model.

## Interface
- ADDR_W, 32, address width on core and memory sides

- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- req_valid_i  in  1  memory-stage access present this cycle
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  00 byte, 01 half, 10 word; 11 treated as word
- req_unsigned_i  in  1  zero-extend load (LBU/LHU)
- req_addr_i  in  ADDR_W  byte address
- req_wdata_i  in  32  store data, right-aligned
- stall_o  out  1  core must hold its memory-stage request this cycle
- misalign_o  out  1  combinational; current request misaligned
- rdata_o  out  32  extended load result; 0 when rdata_valid_o = 0
- rdata_valid_o  out  1  rdata_o valid (load result)
- mem_addr_o  out  ADDR_W  word-aligned address to RAM (addr[1:0] forced 0)
- mem_wdata_o  out  32  write word to RAM
- mem_write_o  out  1  RAM write strobe
- mem_read_o  out  1  RAM read strobe
- mem_rdata_i  in  32  RAM read data, valid one cycle after mem_read_o

## Operation
- Little-endian; lane k = bits [8k+7:8k], k = addr[1:0].
- Misaligned: half with addr[0]=1; word with addr[1:0]≠00. misalign_o=1 same cycle, mem_read_o=mem_write_o=0, no state change.
- States: IDLE, LOAD_WAIT, RMW_WR.
- IDLE, aligned load: mem_read_o=1; latch addr[1:0], size, unsigned; -> LOAD_WAIT.
- LOAD_WAIT: extract lane(s) from mem_rdata_i, sign/zero extend to rdata_o, rdata_valid_o=1. A new request in this cycle is accepted as in IDLE (back-to-back loads allowed).
- IDLE, word store: mem_write_o=1, mem_wdata_o=req_wdata_i, stays IDLE, no stall.
- IDLE, byte/half store: mem_read_o=1, stall_o=1; latch addr, size, wdata; -> RMW_WR.
- RMW_WR: merged word = mem_rdata_i with target lane(s) replaced by wdata[7:0] / wdata[15:0]; mem_write_o=1 at latched address; stall_o=0; request inputs ignored (they are the held store); -> IDLE.
- mem_addr_o = latched address in RMW_WR, else req_addr_i with [1:0]=0.
- req_valid_i=0: no strobes, LOAD_WAIT/RMW_WR still complete.

## Timing
- Reset: state IDLE; stall_o, mem_read_o, mem_write_o, rdata_valid_o = 0; rdata_o = 0; latched fields cleared.
- Load latency: request cycle N, rdata_valid_o in N+1 (matches the core's one-cycle DMEM_data_i expectation).
- Word store: 1 cycle. Sub-word store: 2 cycles, stall_o high only in the first.
- Never mem_read_o and mem_write_o both high in one cycle.
- Reset in LOAD_WAIT or RMW_WR: next cycle IDLE, no write issued, rdata_valid_o=0.
- Store request in LOAD_WAIT: word store writes immediately; sub-word store starts RMW while load result still returned that cycle.

## Test plan
- RAM[0x100]=0x80FF1234; LB 0x103 -> rdata_o 0xFFFFFF80 at N+1; LBU 0x103 -> 0x00000080; LB 0x100 -> 0x00000034.
- Same word; LH 0x102 -> 0xFFFF80FF; LHU 0x102 -> 0x000080FF; LW 0x100 -> 0x80FF1234.
- RAM[0x200]=0x11223344; SB 0xAB @0x201 -> stall_o 1 cycle, mem_write_o at N+1, word 0x1122AB44; SH 0xBEEF @0x202 -> 0xBEEF3344 result 0xBEEFAB44.
- LW 0x102, SH 0x203 -> misalign_o=1, no mem_read_o/mem_write_o, RAM unchanged.
- Reset_n low during RMW_WR of SB -> no mem_write_o, RAM unchanged, outputs at reset values next cycle.
- SB then immediate LBU same byte -> load returns stored byte; LW,LW back-to-back -> two consecutive rdata_valid_o cycles with correct data.
